// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light controller: state codes, lamp
// patterns, default intervals and state-to-lamp decoding.
package tlc_pkg;

  typedef enum logic [2:0] {
    S_MG1  = 3'd0,
    S_MG2  = 3'd1,
    S_MY   = 3'd2,
    S_WALK = 3'd3,
    S_SG   = 3'd4,
    S_SGX  = 3'd5,
    S_SY   = 3'd6
  } state_t;

  // Lamp vectors are {R,Y,G}.
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam int T_BASE_DEF  = 6;
  localparam int T_EXT_DEF   = 3;
  localparam int T_YEL_DEF   = 2;
  localparam int TIMER_W_DEF = 4;

  function automatic logic [2:0] main_lamp(input state_t s);
    case (s)
      S_MG1, S_MG2: return LAMP_G;
      S_MY:         return LAMP_Y;
      default:      return LAMP_R;
    endcase
  endfunction

  function automatic logic [2:0] side_lamp(input state_t s);
    case (s)
      S_SG, S_SGX: return LAMP_G;
      S_SY:        return LAMP_Y;
      default:     return LAMP_R;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_fsm_if.sv
// Signal bundle between the traffic-light sequencer and its surroundings.
// Inputs are level signals sampled on the rising clock edge; outputs are registered.
interface traffic_light_fsm_if;
  logic       Tick;
  logic       Sensor;
  logic       WR;
  logic [2:0] Main_Light;
  logic [2:0] Side_Light;
  logic       Walk_Light;
  logic       WR_Reset;
  logic [2:0] State;

  modport master (
    output Tick, Sensor, WR,
    input  Main_Light, Side_Light, Walk_Light, WR_Reset, State
  );

  modport slave (
    input  Tick, Sensor, WR,
    output Main_Light, Side_Light, Walk_Light, WR_Reset, State
  );
endinterface

// File: rtl/interval_timer.sv
// Down-counter of Tick pulses; expired marks the Tick that ends the interval.
// A load takes precedence over counting so a new interval starts cleanly.
module interval_timer
  import tlc_pkg::*;
#(
  parameter int                   TIMER_W     = TIMER_W_DEF,
  parameter logic [TIMER_W-1:0]   RESET_VALUE = '0
) (
  input  logic               clock,
  input  logic               Reset_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  input  logic               Tick,
  output logic               expired
);

  logic [TIMER_W-1:0] count;

  assign expired = Tick && (count == '0);

  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      count <= RESET_VALUE;
    end else if (load) begin
      count <= load_value;
    end else if (Tick) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/traffic_light_fsm.sv
// Main/side street light sequencer with sensor-driven phase lengths and an
// optional pedestrian walk phase that clears the walk register on entry.
module traffic_light_fsm
  import tlc_pkg::*;
#(
  parameter int T_BASE  = T_BASE_DEF,
  parameter int T_EXT   = T_EXT_DEF,
  parameter int T_YEL   = T_YEL_DEF,
  parameter int TIMER_W = TIMER_W_DEF
) (
  input logic                clock,
  input logic                Reset_n,
  traffic_light_fsm_if.slave bus
);

  state_t             state;
  state_t             next_state;
  logic               load;
  logic               expired;
  logic [TIMER_W-1:0] load_value;

  // Interval for the state being entered; MG2 length is chosen by the
  // Sensor value present on the edge that enters it.
  function automatic logic [TIMER_W-1:0] reload(input state_t s, input logic sensor);
    int d;
    case (s)
      S_MG2:         d = sensor ? T_EXT : T_BASE;
      S_MY, S_SY:    d = T_YEL;
      S_WALK, S_SGX: d = T_EXT;
      default:       d = T_BASE;
    endcase
    return TIMER_W'(d - 1);
  endfunction

  interval_timer #(
    .TIMER_W     (TIMER_W),
    .RESET_VALUE (TIMER_W'(T_BASE - 1))
  ) u_timer (
    .clock      (clock),
    .Reset_n    (Reset_n),
    .load       (load),
    .load_value (load_value),
    .Tick       (bus.Tick),
    .expired    (expired)
  );

  always_comb begin
    next_state = state;
    case (state)
      S_MG1:   if (expired) next_state = S_MG2;
      S_MG2:   if (expired) next_state = S_MY;
      S_MY:    if (expired) next_state = bus.WR ? S_WALK : S_SG;
      S_WALK:  if (expired) next_state = S_SG;
      S_SG:    if (expired) next_state = bus.Sensor ? S_SGX : S_SY;
      S_SGX:   if (expired) next_state = S_SY;
      S_SY:    if (expired) next_state = S_MG1;
      default: next_state = S_MG1;
    endcase
  end

  // Every transition is a state entry, so a change of state is the load.
  assign load       = (next_state != state);
  assign load_value = reload(next_state, bus.Sensor);

  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state          <= S_MG1;
      bus.Main_Light <= LAMP_G;
      bus.Side_Light <= LAMP_R;
      bus.Walk_Light <= 1'b0;
      bus.WR_Reset   <= 1'b0;
    end else begin
      state          <= next_state;
      bus.Main_Light <= main_lamp(next_state);
      bus.Side_Light <= side_lamp(next_state);
      bus.Walk_Light <= (next_state == S_WALK);
      bus.WR_Reset   <= (next_state == S_WALK) && (state != S_WALK);
    end
  end

  assign bus.State = state;

endmodule
